// File: rtl/hyperram_responder.sv
// hyperram_responder: HyperBus memory-side responder that stands in for a
// small HyperRAM device so the controller can be exercised without the chip.
//
// Latency: each sampled dram_ck edge is acted on in the clk cycle that detects
// it. dram_dq_in and dram_rwds_in change on the following clk edge.
// Backpressure: none. The responder follows the controller's dram_ck and
// dram_cs_l. A high dram_cs_l aborts any transaction.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   dram_ck           HyperBus clock, oversampled as data
//   dram_cs_l         chip select (low = selected)
//   dram_rst_l        device reset (low), sampled synchronously
//   dram_dq_out/_oe   controller-driven DQ and its enable
//   dram_rwds_out/_oe controller-driven RWDS (write byte mask) and its enable
//   dram_dq_in        responder-driven DQ
//   dram_rwds_in      responder-driven RWDS
//   err_cnt           aborted-transaction counter, saturating
//                     (only with HRAM_RESP_ERRCNT_EN)
//
// Optional feature macro: HRAM_RESP_ERRCNT_EN
module hyperram_responder #(
  parameter int          ADDR_W  = 8,
  parameter int          LAT_CK  = 6,
  parameter bit          LAT_2X  = 1'b1,
  parameter logic [15:0] ID0_VAL = 16'h0C81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dram_ck,
  input  logic       dram_cs_l,
  input  logic       dram_rst_l,
  input  logic [7:0] dram_dq_out,
  input  logic       dram_dq_oe,
  input  logic       dram_rwds_out,
  input  logic       dram_rwds_oe,
  output logic [7:0] dram_dq_in,
  output logic       dram_rwds_in
`ifdef HRAM_RESP_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LAT, S_RD, S_WR, S_REGWR, S_DONE
  } state_t;

  localparam logic [15:0] CR0_RST  = 16'h8F1F;
  localparam logic [7:0]  LAT_INIT = LAT_2X ? 8'(2 * LAT_CK) : 8'(LAT_CK);
  localparam int          DEPTH    = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic              ck_q;
  logic [39:0]       ca_q, ca_d;
  logic [2:0]        edge_cnt_q, edge_cnt_d;
  logic              rw_q, rw_d;
  logic              as_q, as_d;
  logic              reg_hi_q, reg_hi_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        lat_cnt_q, lat_cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic              hi_mask_q, hi_mask_d;
  logic              half_q, half_d;
  logic [15:0]       cr0_q, cr0_d;
  logic [7:0]        dq_in_q, dq_in_d;
  logic              rwds_in_q, rwds_in_d;

  logic [15:0]       mem [DEPTH];
  logic              mem_we_hi, mem_we_lo;

  logic              rise, fall;
  logic              do_rise, do_fall;
  logic [47:0]       ca_shift;
  logic [31:0]       ca_waddr;
  logic [15:0]       rd_word;
  logic              ca_unused;

  assign rise = dram_ck & ~ck_q;
  assign fall = ~dram_ck & ck_q;

  // The CA word after shifting in the byte on the current edge. The decode on
  // the 6th edge uses this value, so the last byte does not need to be
  // registered first.
  assign ca_shift  = {ca_q, dram_dq_out};
  assign ca_waddr  = {ca_shift[44:16], ca_shift[2:0]};
  // Burst type and reserved CA bits carry no meaning for this responder.
  assign ca_unused = ^{ca_shift[45], ca_shift[15:3]};

  // Register space decodes against the full CA word address, not the truncated
  // one. This keeps CR0 at 0x800 distinct from ID0 at 0 for any ADDR_W.
  assign rd_word = as_q ? ((waddr_q == '0 && !reg_hi_q) ? ID0_VAL : cr0_q)
                        : mem[waddr_q];

  always_comb begin
    state_d    = state_q;
    ca_d       = ca_q;
    edge_cnt_d = edge_cnt_q;
    rw_d       = rw_q;
    as_d       = as_q;
    reg_hi_d   = reg_hi_q;
    waddr_d    = waddr_q;
    lat_cnt_d  = lat_cnt_q;
    hi_d       = hi_q;
    hi_mask_d  = hi_mask_q;
    half_d     = half_q;
    cr0_d      = cr0_q;
    dq_in_d    = dq_in_q;
    rwds_in_d  = rwds_in_q;
    mem_we_hi  = 1'b0;
    mem_we_lo  = 1'b0;
    do_rise    = 1'b0;
    do_fall    = 1'b0;

    if (dram_cs_l || !dram_rst_l) begin
      // Deselect wins over any coincident dram_ck edge. Any partial word is dropped.
      state_d   = S_IDLE;
      rwds_in_d = 1'b0;
      half_d    = 1'b0;
      if (!dram_rst_l) cr0_d = CR0_RST;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_CA;
          edge_cnt_d = 3'd0;
          rwds_in_d  = LAT_2X;
        end
        S_CA: begin
          if (rise || fall) begin
            ca_d       = ca_shift[39:0];
            edge_cnt_d = edge_cnt_q + 3'd1;
            if (edge_cnt_q == 3'd5) begin
              rw_d     = ca_shift[47];
              as_d     = ca_shift[46];
              waddr_d  = ca_waddr[ADDR_W-1:0];
              reg_hi_d = (ca_waddr >> ADDR_W) != 32'd0;
              if (!ca_shift[47] && ca_shift[46]) begin
                state_d   = S_REGWR;
                rwds_in_d = 1'b0;
                half_d    = 1'b0;
              end else begin
                state_d   = S_LAT;
                lat_cnt_d = LAT_INIT;
              end
            end
          end
        end
        S_LAT: begin
          if (rise) begin
            // The rise that empties the counter is already the first data edge.
            if (lat_cnt_q <= 8'd1) begin
              lat_cnt_d = 8'd0;
              state_d   = rw_q ? S_RD : S_WR;
              do_rise   = 1'b1;
            end else begin
              lat_cnt_d = lat_cnt_q - 8'd1;
            end
          end
        end
        S_RD, S_WR: begin
          do_rise = rise;
          do_fall = fall;
        end
        S_REGWR: begin
          if (rise) begin
            hi_d   = dram_dq_out;
            half_d = 1'b1;
          end else if (fall && half_q) begin
            cr0_d   = {hi_q, dram_dq_out};
            half_d  = 1'b0;
            state_d = S_DONE;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase

      if (do_rise) begin
        if (rw_q) begin
          dq_in_d   = rd_word[15:8];
          rwds_in_d = 1'b1;
          half_d    = 1'b1;
        end else begin
          rwds_in_d = 1'b0;
          if (dram_dq_oe) begin
            hi_d      = dram_dq_out;
            hi_mask_d = dram_rwds_oe & dram_rwds_out;
            half_d    = 1'b1;
          end
        end
      end

      if (do_fall) begin
        if (rw_q) begin
          dq_in_d   = rd_word[7:0];
          rwds_in_d = 1'b0;
          waddr_d   = waddr_q + ADDR_W'(1);
          half_d    = 1'b0;
        end else if (dram_dq_oe && half_q) begin
          mem_we_hi = !hi_mask_q;
          mem_we_lo = !(dram_rwds_oe & dram_rwds_out);
          waddr_d   = waddr_q + ADDR_W'(1);
          half_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ck_q       <= 1'b0;
      ca_q       <= '0;
      edge_cnt_q <= 3'd0;
      rw_q       <= 1'b0;
      as_q       <= 1'b0;
      reg_hi_q   <= 1'b0;
      waddr_q    <= '0;
      lat_cnt_q  <= 8'd0;
      hi_q       <= 8'd0;
      hi_mask_q  <= 1'b0;
      half_q     <= 1'b0;
      cr0_q      <= CR0_RST;
      dq_in_q    <= 8'd0;
      rwds_in_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ck_q       <= dram_ck;
      ca_q       <= ca_d;
      edge_cnt_q <= edge_cnt_d;
      rw_q       <= rw_d;
      as_q       <= as_d;
      reg_hi_q   <= reg_hi_d;
      waddr_q    <= waddr_d;
      lat_cnt_q  <= lat_cnt_d;
      hi_q       <= hi_d;
      hi_mask_q  <= hi_mask_d;
      half_q     <= half_d;
      cr0_q      <= cr0_d;
      dq_in_q    <= dq_in_d;
      rwds_in_q  <= rwds_in_d;
    end
  end

  // No reset on the array. While reset is held, state is IDLE, so no write
  // enable can fire and an in-flight word is never committed.
  always_ff @(posedge clk) begin
    if (mem_we_hi) mem[waddr_q][15:8] <= hi_q;
    if (mem_we_lo) mem[waddr_q][7:0]  <= dram_dq_out;
  end

  assign dram_dq_in   = dq_in_q;
  assign dram_rwds_in = rwds_in_q;

`ifdef HRAM_RESP_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       abort;

  // Abort = deselect before the access is complete: during CA or latency,
  // or between the rise and fall of a data word.
  assign abort = dram_cs_l &&
                 (state_q == S_CA || state_q == S_LAT ||
                  (half_q && (state_q == S_RD || state_q == S_WR ||
                              state_q == S_REGWR)));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (abort && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hyperram_responder.sv
// tb_hyperram_responder: acts as a HyperBus controller driving the responder.
// dram_ck is toggled every two clk cycles. A word-array model predicts the
// memory contents, CR0 and the read data returned for each burst.
module tb_hyperram_responder;

  localparam int          ADDR_W  = 8;
  localparam int          LAT_CK  = 6;
  localparam bit          LAT_2X  = 1'b1;
  localparam logic [15:0] ID0_VAL = 16'h0C81;
  localparam logic [15:0] CR0_RST = 16'h8F1F;
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam int          LAT     = LAT_2X ? 2 * LAT_CK : LAT_CK;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dram_ck = 1'b0;
  logic       dram_cs_l = 1'b1;
  logic       dram_rst_l = 1'b1;
  logic [7:0] dram_dq_out = 8'd0;
  logic       dram_dq_oe = 1'b0;
  logic       dram_rwds_out = 1'b0;
  logic       dram_rwds_oe = 1'b0;
  logic [7:0] dram_dq_in;
  logic       dram_rwds_in;
`ifdef HRAM_RESP_ERRCNT_EN
  logic [7:0] err_cnt;
  int         err_exp = 0;
`endif

  always #5 clk = ~clk;

  hyperram_responder #(
    .ADDR_W (ADDR_W),
    .LAT_CK (LAT_CK),
    .LAT_2X (LAT_2X),
    .ID0_VAL(ID0_VAL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dram_ck      (dram_ck),
    .dram_cs_l    (dram_cs_l),
    .dram_rst_l   (dram_rst_l),
    .dram_dq_out  (dram_dq_out),
    .dram_dq_oe   (dram_dq_oe),
    .dram_rwds_out(dram_rwds_out),
    .dram_rwds_oe (dram_rwds_oe),
    .dram_dq_in   (dram_dq_in),
    .dram_rwds_in (dram_rwds_in)
`ifdef HRAM_RESP_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mdl_mem [DEPTH];
  logic [15:0] mdl_cr0 = CR0_RST;
  logic [15:0] wbuf [16];
  logic        wmh [16];
  logic        wml [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] make_ca(input logic rw, input logic is_reg, input logic [31:0] a);
    logic [47:0] c;
    c         = '0;
    c[47]     = rw;
    c[46]     = is_reg;
    c[45]     = 1'b1;
    c[44:16]  = a[31:3];
    c[2:0]    = a[2:0];
    return c;
  endfunction

  // One dram_ck transition held for two clk cycles. The task returns at a
  // negedge where the responder has registered its reaction to the edge.
  task automatic ck_edge(input logic lvl, input logic [7:0] dq, input logic oe,
                         input logic rw, input logic rw_oe);
    @(negedge clk);
    dram_ck       = lvl;
    dram_dq_out   = dq;
    dram_dq_oe    = oe;
    dram_rwds_out = rw;
    dram_rwds_oe  = rw_oe;
    @(negedge clk);
  endtask

  task automatic txn_start(input logic [47:0] ca);
    @(negedge clk);
    dram_cs_l = 1'b0;
    dram_ck   = 1'b0;
    @(negedge clk);
    chk("ca_rwds", {31'd0, dram_rwds_in}, {31'd0, LAT_2X});
    for (int i = 0; i < 6; i++) ck_edge(~i[0], ca[47-8*i -: 8], 1'b1, 1'b0, 1'b0);
  endtask

  // LAT-1 idle clock cycles. The rise after them carries the first data.
  task automatic latency();
    for (int i = 0; i < LAT - 1; i++) begin
      ck_edge(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      ck_edge(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("lat_rwds", {31'd0, dram_rwds_in}, {31'd0, LAT_2X});
  endtask

  task automatic txn_end();
    @(negedge clk);
    dram_cs_l    = 1'b1;
    dram_ck      = 1'b0;
    dram_dq_oe   = 1'b0;
    dram_rwds_oe = 1'b0;
    @(negedge clk);
    chk("end_rwds", {31'd0, dram_rwds_in}, 32'd0);
    @(negedge clk);
  endtask

  task automatic mem_write(input int addr, input int n);
    int a;
    txn_start(make_ca(1'b0, 1'b0, addr));
    latency();
    for (int i = 0; i < n; i++) begin
      ck_edge(1'b1, wbuf[i][15:8], 1'b1, wmh[i], 1'b1);
      ck_edge(1'b0, wbuf[i][7:0],  1'b1, wml[i], 1'b1);
      a = (addr + i) % DEPTH;
      if (!wmh[i]) mdl_mem[a][15:8] = wbuf[i][15:8];
      if (!wml[i]) mdl_mem[a][7:0]  = wbuf[i][7:0];
    end
    txn_end();
  endtask

  task automatic mem_read(input int addr, input int n, input logic is_reg);
    logic [15:0] exp;
    txn_start(make_ca(1'b1, is_reg, addr));
    latency();
    for (int i = 0; i < n; i++) begin
      if (is_reg) exp = (addr + i == 0) ? ID0_VAL : mdl_cr0;
      else        exp = mdl_mem[(addr + i) % DEPTH];
      ck_edge(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("rd_hi",   {24'd0, dram_dq_in}, {24'd0, exp[15:8]});
      chk("rd_rwds_hi", {31'd0, dram_rwds_in}, 32'd1);
      ck_edge(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("rd_lo",   {24'd0, dram_dq_in}, {24'd0, exp[7:0]});
      chk("rd_rwds_lo", {31'd0, dram_rwds_in}, 32'd0);
    end
    txn_end();
  endtask

  task automatic reg_write(input logic [15:0] w);
    txn_start(make_ca(1'b0, 1'b1, 32'h800));
    ck_edge(1'b1, w[15:8], 1'b1, 1'b0, 1'b0);
    ck_edge(1'b0, w[7:0],  1'b1, 1'b0, 1'b0);
    mdl_cr0 = w;
    // Further edges after the register word must be ignored.
    ck_edge(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    ck_edge(1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
    txn_end();
  endtask

  // Called at a negedge in the middle of a burst.
  task automatic reset_now();
    reset = 1'b1;
    #1;
    chk("rst_dq",   {24'd0, dram_dq_in}, 32'd0);
    chk("rst_rwds", {31'd0, dram_rwds_in}, 32'd0);
    dram_cs_l    = 1'b1;
    dram_ck      = 1'b0;
    dram_dq_oe   = 1'b0;
    dram_rwds_oe = 1'b0;
    mdl_cr0      = CR0_RST;
`ifdef HRAM_RESP_ERRCNT_EN
    err_exp = 0;
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int a, n;
    repeat (3) @(negedge clk);
    chk("reset_dq",   {24'd0, dram_dq_in}, 32'd0);
    chk("reset_rwds", {31'd0, dram_rwds_in}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fill the whole array so that every later read has a known expectation.
    for (int b = 0; b < DEPTH / 16; b++) begin
      for (int i = 0; i < 16; i++) begin
        wbuf[i] = 16'($urandom);
        wmh[i]  = 1'b0;
        wml[i]  = 1'b0;
      end
      mem_write(b * 16, 16);
    end

    // Basic write then read back at word 5.
    wbuf[0] = 16'h1234; wbuf[1] = 16'h5678;
    wmh[0] = 0; wml[0] = 0; wmh[1] = 0; wml[1] = 0;
    mem_write(5, 2);
    mem_read(5, 2, 1'b0);
    chk("mem5", {16'd0, mdl_mem[5]}, 32'h1234);

    // Byte mask: write FFFF, then write ABCD with the high byte masked.
    wbuf[0] = 16'hFFFF; wmh[0] = 0; wml[0] = 0;
    mem_write(5, 1);
    wbuf[0] = 16'hABCD; wmh[0] = 1; wml[0] = 0;
    mem_write(5, 1);
    mem_read(5, 1, 1'b0);

    // Address wrap from the top word back to 0.
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin wmh[i] = 0; wml[i] = 0; end
    mem_write(DEPTH - 1, 3);
    mem_read(DEPTH - 1, 3, 1'b0);

    // Register space: ID0, the CR0 reset value, a CR0 write, and a device reset.
    mem_read(0, 1, 1'b1);
    mem_read(32'h800, 1, 1'b1);
    reg_write(16'h8F17);
    mem_read(32'h800, 1, 1'b1);
    mem_read(0, 1, 1'b1);
    @(negedge clk); dram_rst_l = 1'b0;
    @(negedge clk); dram_rst_l = 1'b1;
    mdl_cr0 = CR0_RST;
    mem_read(32'h800, 1, 1'b1);
    reg_write(16'h8F17);

    // Abort during CA. The CS rise coincides with a falling dram_ck.
    @(negedge clk); dram_cs_l = 1'b0;
    @(negedge clk);
    ck_edge(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0);
    ck_edge(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    ck_edge(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    txn_end();
`ifdef HRAM_RESP_ERRCNT_EN
    err_exp++;
`endif
    mem_read(5, 2, 1'b0);
`ifdef HRAM_RESP_ERRCNT_EN
    chk("err_cnt", {24'd0, err_cnt}, err_exp);
`endif

    // Randomized bursts with random byte masks, each followed by a random read.
    for (int t = 0; t < 20; t++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 16'($urandom);
        wmh[i]  = ($urandom_range(0, 3) == 0);
        wml[i]  = ($urandom_range(0, 3) == 0);
      end
      mem_write(a, n);
      mem_read((a + int'($urandom_range(0, 3))) % DEPTH, int'($urandom_range(1, 8)), 1'b0);
    end

    // Async reset mid-read. The next transaction must decode normally.
    txn_start(make_ca(1'b1, 1'b0, 10));
    latency();
    ck_edge(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_rd_hi", {24'd0, dram_dq_in}, {24'd0, mdl_mem[10][15:8]});
    reset_now();
    mem_read(10, 2, 1'b0);
    mem_read(32'h800, 1, 1'b1);

    // Async reset mid-write. Only the completed first word may land.
    txn_start(make_ca(1'b0, 1'b0, 20));
    latency();
    wbuf[0] = 16'($urandom);
    wbuf[1] = ~mdl_mem[21];
    ck_edge(1'b1, wbuf[0][15:8], 1'b1, 1'b0, 1'b1);
    ck_edge(1'b0, wbuf[0][7:0],  1'b1, 1'b0, 1'b1);
    mdl_mem[20] = wbuf[0];
    ck_edge(1'b1, wbuf[1][15:8], 1'b1, 1'b0, 1'b1);
    reset_now();
    mem_read(20, 2, 1'b0);

`ifdef HRAM_RESP_ERRCNT_EN
    chk("err_cnt_end", {24'd0, err_cnt}, err_exp);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hyperram_responder.md
Name: hyperram_responder

Overview:
- Synthesizable HyperBus memory-side responder: emulates a small HyperRAM device on the far side of the pins the controller drives.
- Lets the existing controller and UART command path be exercised on FPGA, or in simulation, without the physical chip.
- Oversamples `dram_ck` in the system clock domain and decodes CA, latency, burst read/write and register-space access.
- Backed by an internal word array.

Parameters:
- ADDR_W, 8, word-address width of the memory array (depth 2^ADDR_W 16-bit words)
- LAT_CK, 6, initial latency in dram_ck cycles (1x)
- LAT_2X, 1, 1 = always double latency (2*LAT_CK) and drive rwds_in high during CA; 0 = 1x latency with rwds_in low
- ID0_VAL, 16'h0C81, value returned by register-space read at word address 0

Ports:
- clk  in  1  system clock; also clocks the controller that generates dram_ck
- reset  in  1  asynchronous, active-high
- dram_ck  in  1  HyperBus clock from controller, sampled as data
- dram_cs_l  in  1  chip select, active low
- dram_rst_l  in  1  device reset, active low, sampled synchronously
- dram_dq_out  in  8  controller-driven DQ
- dram_dq_oe  in  1  controller DQ output enable, active high
- dram_rwds_out  in  1  controller-driven RWDS (write mask)
- dram_rwds_oe  in  1  controller RWDS output enable, active high
- dram_dq_in  out  8  responder-driven DQ toward controller
- dram_rwds_in  out  1  responder-driven RWDS toward controller

Behaviour:
- Reset values: dram_dq_in=0, dram_rwds_in=0, state=IDLE, cr0=16'h8F1F; memory contents undefined.
- Edge detect:
  - ck_q <= dram_ck each clk.
  - rise = dram_ck & ~ck_q; fall = ~dram_ck & ck_q.
  - All protocol actions occur on the clk cycle of a detected edge.
  - Outputs update on the following clk edge (1 clk latency).
- dram_cs_l high in any state: next cycle state=IDLE, dram_rwds_in=0, dram_dq_in holds; partial words discarded.
- dram_rst_l low: same as CS high, plus cr0 <= 16'h8F1F.
- States:
  - IDLE: on dram_cs_l low -> CA with edge count 0; dram_rwds_in <= LAT_2X.
  - CA:
    - Shift dram_dq_out into 48-bit ca on each rise/fall, MSB first.
    - After 6th edge (a fall): rw=ca[47] (1=read), as=ca[46] (1=register), waddr={ca[44:16],ca[2:0]} truncated to ADDR_W.
    - Register write -> REGWR.
    - Otherwise -> LAT with lat_cnt = LAT_2X ? 2*LAT_CK : LAT_CK.
  - LAT:
    - Decrement lat_cnt on each rise.
    - When the rise that makes lat_cnt 0 occurs, that same rise is the first data edge -> RD or WR.
  - RD:
    - On rise: dram_dq_in <= word[15:8], dram_rwds_in <= 1.
    - On fall: dram_dq_in <= word[7:0], dram_rwds_in <= 0, waddr <= waddr+1.
    - waddr wraps 2^ADDR_W-1 -> 0.
    - word = mem[waddr] for memory space; for register space: ID0_VAL if waddr==0, else cr0.
  - WR:
    - On rise: hi byte latched, hi mask = dram_rwds_out.
    - On fall: write mem[waddr] byte lanes whose mask is 0, then waddr+1 with wrap.
    - Edges with dram_dq_oe=0 are ignored.
    - RWDS mask ignored if dram_rwds_oe=0 (treated as unmasked).
  - REGWR:
    - Zero latency; next rise = hi byte, following fall = lo byte.
    - cr0 <= word, then -> DONE.
  - DONE: ignore edges until dram_cs_l high.
- dram_rwds_in is 0 in WR, REGWR, DONE; holds LAT_2X value in CA and LAT.
- Simultaneous CS rise and ck edge: CS wins; no data captured on that edge.
- Async reset mid-burst: immediate return to reset values; an in-flight write word is not committed.

Optional Feature:
- Macro: HRAM_RESP_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset 0, saturating at 8'hFF.
  - Increments once per transaction where dram_cs_l rises in CA, LAT, or mid-word (after rise, before fall) in RD/WR/REGWR.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Write then read: write CA 20_00_00_00_00_05, LAT_2X=1, LAT_CK=6; data 12 34 56 78 with RWDS low -> mem[5]=1234, mem[6]=5678. Read CA A0_00_00_00_00_05 -> dram_dq_in 12,34,56,78 after 12 ck; rwds_in toggles 1,0,1,0; rwds_in=1 during CA.
- Byte mask: write mem[5]=FFFF with hi-byte RWDS=1, data AB CD -> mem[5]=FFCD.
- Wrap: ADDR_W=8, 3-word write at waddr 255 with data 1111, 2222, 3333 -> mem[255]=1111, mem[0]=2222, mem[1]=3333.
- Register: write CA 60_00_01_00_00_00 with data 8F 17 (zero latency) -> cr0=8F17. Register read at waddr 0 returns 0C81; register read at waddr 0x800 returns 8F17.
- Abort: CS high after 3 CA bytes, then a normal read at 5 -> read returns correct data. With HRAM_RESP_ERRCNT_EN, err_cnt=1.
- Reset: assert reset mid-read -> dram_dq_in=0 and dram_rwds_in=0 in the same cycle; the next transaction decodes normally.
